cv32e40x_amo_sequencer: RTL and testbench

- Sequences RV32A word atomics (lsu_atop[5]=1) as split read/modify/write transactions on an OBI-style data port.
- Used for memory regions whose interconnect does not support native atop.
- Sits between the LSU and the data bus; holds the single LR/SC reservation.
- One atomic in flight at a time; non-atomic traffic never enters this block.

---
 rtl/cv32e40x_pkg.sv | 43 ++++
 rtl/cv32e40x_amo_alu.sv | 31 +++
 rtl/cv32e40x_amo_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cv32e40x_amo_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_pkg.sv
// Purpose: shared types and constants for the atomic-memory-operation sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cv32e40x_pkg;

    // RV32A funct5 encodings (atop[4:0]; atop[5] marks the access as atomic)
    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        AMO_IDLE,
        AMO_RD_REQ,
        AMO_RD_WAIT,
        AMO_WR_REQ,
        AMO_WR_WAIT,
        AMO_RESP
    } amo_seq_state_e;

    // Word address is stored in full; the sequencer compares only the bits
    // above its reservation granule, so one struct serves every granule size.
    typedef struct packed {
        logic        valid;
        logic [31:2] addr;
    } amo_res_t;

    function automatic logic amo_funct5_legal(input logic [4:0] funct5);
        case (funct5)
            AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40x_amo_alu.sv
// Purpose: combinational modify step of an AMO: new_val = f(old, b).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: funct5 selects the op, old is the memory word, b is rs2, new_val the result.
module cv32e40x_amo_alu
    import cv32e40x_pkg::*;
(
    input  logic [4:0]  funct5,
    input  logic [31:0] old,
    input  logic [31:0] b,
    output logic [31:0] new_val
);

    always_comb begin
        new_val = old;
        case (funct5)
            AMO_SWAP: new_val = b;
            AMO_ADD:  new_val = old + b;
            AMO_XOR:  new_val = old ^ b;
            AMO_AND:  new_val = old & b;
            AMO_OR:   new_val = old | b;
            // Strict compares so that equal operands keep old
            AMO_MIN:  new_val = ($signed(b) < $signed(old)) ? b : old;
            AMO_MAX:  new_val = ($signed(b) > $signed(old)) ? b : old;
            AMO_MINU: new_val = (b < old) ? b : old;
            AMO_MAXU: new_val = (b > old) ? b : old;
            default:  new_val = old;
        endcase
    end

endmodule

// File: rtl/cv32e40x_amo_sequencer.sv
// Purpose: runs RV32A word atomics as split read/modify/write OBI transactions; owns the LR/SC reservation.
// Latency: zero-wait bus, accept to resp_valid inclusive: AMO 6, LR 4, SC hit 4, SC miss / decode error 2 cycles.
// Backpressure: req_ready only in IDLE (one atomic in flight); bus phases hold until gnt; response has no backpressure.
// Ports: req_* from the LSU, resp_* one-cycle result pulse, res_clear_i kills the reservation, bus_* OBI data port.
module cv32e40x_amo_sequencer
    import cv32e40x_pkg::*;
#(
    parameter int unsigned RES_GRAN_LSB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [5:0]  req_atop_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    input  logic        res_clear_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    amo_seq_state_e state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [31:2]    addr_q, addr_d;
    logic [31:0]    operand_q, operand_d;
    logic [31:0]    old_q, old_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    amo_res_t       res_q, res_d;

    logic [31:0]    alu_result;
    logic           req_bad;
    logic           sc_hit;
    logic           wr_hits_res;

    assign req_bad = (req_addr_i[1:0] != 2'b00) || !req_atop_i[5]
                   || !amo_funct5_legal(req_atop_i[4:0]);

    // A clear arriving in the SC accept cycle must beat the reservation
    assign sc_hit = res_q.valid && !res_clear_i
                  && (res_q.addr[31:RES_GRAN_LSB] == req_addr_i[31:RES_GRAN_LSB]);

    assign wr_hits_res = res_q.valid
                       && (res_q.addr[31:RES_GRAN_LSB] == addr_q[31:RES_GRAN_LSB]);

    // Modify straight off the read bus so the write can be issued next cycle
    cv32e40x_amo_alu u_alu (
        .funct5  (op_q),
        .old     (bus_rdata_i),
        .b       (operand_q),
        .new_val (alu_result)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        old_d     = old_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        res_d     = res_q;

        case (state_q)
            AMO_IDLE: begin
                if (req_valid_i) begin
                    op_d      = req_atop_i[4:0];
                    addr_d    = req_addr_i[31:2];
                    operand_d = req_wdata_i;
                    rdata_d   = 32'h0;
                    err_d     = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = AMO_RESP;
                    end else if (req_atop_i[4:0] == AMO_SC) begin
                        res_d.valid = 1'b0;
                        if (sc_hit) begin
                            wdata_d = req_wdata_i;
                            state_d = AMO_WR_REQ;
                        end else begin
                            rdata_d = 32'h1;
                            state_d = AMO_RESP;
                        end
                    end else begin
                        state_d = AMO_RD_REQ;
                    end
                end
            end
            AMO_RD_REQ: begin
                if (bus_gnt_i) state_d = AMO_RD_WAIT;
            end
            AMO_RD_WAIT: begin
                if (bus_rvalid_i) begin
                    old_d = bus_rdata_i;
                    if (bus_err_i) begin
                        err_d   = 1'b1;
                        state_d = AMO_RESP;
                    end else if (op_q == AMO_LR) begin
                        res_d.valid = 1'b1;
                        res_d.addr  = addr_q;
                        rdata_d     = bus_rdata_i;
                        state_d     = AMO_RESP;
                    end else begin
                        wdata_d = alu_result;
                        state_d = AMO_WR_REQ;
                    end
                end
            end
            AMO_WR_REQ: begin
                if (bus_gnt_i) begin
                    if (op_q != AMO_SC && wr_hits_res) res_d.valid = 1'b0;
                    state_d = AMO_WR_WAIT;
                end
            end
            AMO_WR_WAIT: begin
                if (bus_rvalid_i) begin
                    err_d   = bus_err_i;
                    rdata_d = (op_q == AMO_SC) ? {31'h0, bus_err_i} : old_q;
                    state_d = AMO_RESP;
                end
            end
            AMO_RESP: begin
                state_d = AMO_IDLE;
            end
            default: begin
                state_d = AMO_IDLE;
            end
        endcase

        if (res_clear_i) res_d.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= AMO_IDLE;
            op_q      <= 5'h0;
            addr_q    <= 30'h0;
            operand_q <= 32'h0;
            old_q     <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            operand_q <= operand_d;
            old_q     <= old_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            res_q     <= res_d;
        end
    end

    assign req_ready_o  = (state_q == AMO_IDLE);
    assign resp_valid_o = (state_q == AMO_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign bus_req_o    = (state_q == AMO_RD_REQ) || (state_q == AMO_WR_REQ);
    assign bus_we_o     = (state_q == AMO_WR_REQ);
    assign bus_be_o     = 4'hF;
    assign bus_addr_o   = {addr_q, 2'b00};
    assign bus_wdata_o  = wdata_q;

endmodule

// File: tb/tb_cv32e40x_amo_sequencer.sv
// Purpose: randomized + directed bench for the AMO sequencer against a behavioural model and an OBI memory.
// Latency: n/a (testbench).
// Backpressure: bus model grants after a programmable number of waiting cycles.
module tb_cv32e40x_amo_sequencer;

    localparam logic [4:0] F_ADD  = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010,
                           F_SC   = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000,
                           F_AND  = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100,
                           F_MINU = 5'b11000, F_MAXU = 5'b11100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [5:0]  req_atop;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        res_clear, res_clear_drv, clr_bus;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    assign res_clear = res_clear_drv | clr_bus;

    always #5 clk = ~clk;

    cv32e40x_amo_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_atop_i   (req_atop),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .res_clear_i  (res_clear),
        .bus_req_o    (bus_req),
        .bus_gnt_i    (bus_gnt),
        .bus_addr_o   (bus_addr),
        .bus_we_o     (bus_we),
        .bus_be_o     (bus_be),
        .bus_wdata_o  (bus_wdata),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .bus_err_i    (bus_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // ---------------- OBI memory model ----------------
    logic [31:0] bus_mem [1024];
    logic [31:0] ref_mem [1024];
    int          gnt_delay = 0;
    int          wait_cnt  = 0;
    int          n_rd = 0, n_wr = 0, n_req_cyc = 0;
    bit          granted = 0, drop_resp = 0, inject_rd_err = 0, clr_on_rd = 0;
    logic        g_we;
    logic [31:0] g_addr, g_wdata, h_addr, h_wdata;
    logic        h_we;

    initial begin : bus_model
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0; clr_bus = 1'b0;
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0; clr_bus = 1'b0;
            if (granted) begin
                granted = 0;
                if (!drop_resp) begin
                    bus_rvalid = 1'b1;
                    if (g_we) begin
                        bus_mem[g_addr[11:2]] = g_wdata;
                    end else begin
                        bus_rdata = bus_mem[g_addr[11:2]];
                        if (inject_rd_err) begin bus_err = 1'b1; inject_rd_err = 0; end
                        if (clr_on_rd) begin clr_bus = 1'b1; clr_on_rd = 0; end
                    end
                end
                drop_resp = 0;
            end
            bus_gnt = 1'b0;
            if (bus_req && rst_n) begin
                n_req_cyc++;
                if (wait_cnt == 0) begin
                    h_addr = bus_addr; h_we = bus_we; h_wdata = bus_wdata;
                end else begin
                    chk("hold_addr",  bus_addr, h_addr);
                    chk("hold_we",    32'(bus_we), 32'(h_we));
                    chk("hold_wdata", bus_wdata, h_wdata);
                end
                if (wait_cnt >= gnt_delay) begin
                    bus_gnt = 1'b1; granted = 1;
                    g_we = bus_we; g_addr = bus_addr; g_wdata = bus_wdata;
                    wait_cnt = 0;
                    if (g_we) n_wr++; else n_rd++;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    bit          m_res_vld = 0;
    logic [29:0] m_res_word = '0;

    function automatic bit is_legal(input logic [4:0] f);
        logic [4:0] ops [11] = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                                 F_MIN, F_MAX, F_MINU, F_MAXU};
        foreach (ops[i]) if (ops[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f)
            F_SWAP: return b;
            F_ADD:  return a + b;
            F_XOR:  return a ^ b;
            F_AND:  return a & b;
            F_OR:   return a | b;
            F_MIN:  return (sa <= sb) ? a : b;
            F_MAX:  return (sa >= sb) ? a : b;
            F_MINU: return (a <= b) ? a : b;
            F_MAXU: return (a >= b) ? a : b;
            default: return a;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_bus_req"},    32'(bus_req), 32'd0);
        chk({tag, "_bus_we"},     32'(bus_we), 32'd0);
        chk({tag, "_bus_addr"},   bus_addr, 32'd0);
        chk({tag, "_bus_wdata"},  bus_wdata, 32'd0);
        chk({tag, "_bus_be"},     32'(bus_be), 32'hF);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk); res_clear_drv = 1'b1;
        @(negedge clk); res_clear_drv = 1'b0;
        m_res_vld = 0;
    endtask

    task automatic do_op(input logic [5:0] atop, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit seen, output bit one_cycle);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_atop = atop; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 0; lat = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; lat = i; rd = resp_rdata; er = resp_err; break; end
        end
        @(negedge clk);
        one_cycle = !resp_valid;
    endtask

    task automatic run_op(input string tag, input logic [5:0] atop, input logic [31:0] addr, input logic [31:0] wd);
        logic [4:0]  f;
        logic [31:0] old, e_rd, e_wr, rd;
        logic        e_err, er;
        bit          bad, clr_hit, rd_err, chk_rd, seen, one_cycle;
        int          e_lat, e_rds, e_wrs, lat, r0, w0, q0;
        f = atop[4:0];
        old = ref_mem[addr[11:2]];
        bad = (addr[1:0] != 2'b00) || !atop[5] || !is_legal(f);
        clr_hit = clr_on_rd; rd_err = inject_rd_err;
        e_rd = '0; e_wr = '0; e_err = 1'b0; e_lat = 1; e_rds = 0; e_wrs = 0; chk_rd = 1;
        if (bad) begin
            e_err = 1'b1;
        end else if (f == F_SC) begin
            if (m_res_vld && m_res_word == addr[31:2]) begin
                e_wr = wd; e_wrs = 1; e_lat = 3;
            end else begin
                e_rd = 32'd1;
            end
            m_res_vld = 0;
        end else begin
            e_rds = 1; e_lat = 3;
            if (rd_err) begin
                e_err = 1'b1; chk_rd = 0;
            end else if (f == F_LR) begin
                e_rd = old;
                if (clr_hit) m_res_vld = 0;
                else begin m_res_vld = 1; m_res_word = addr[31:2]; end
            end else begin
                e_rd = old; e_wr = ref_alu(f, old, wd); e_wrs = 1; e_lat = 5;
                if (m_res_word == addr[31:2]) m_res_vld = 0;
            end
        end
        if (e_wrs != 0) ref_mem[addr[11:2]] = e_wr;
        r0 = n_rd; w0 = n_wr; q0 = n_req_cyc;
        do_op(atop, addr, wd, rd, er, lat, seen, one_cycle);
        chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_resp_pulse"}, 32'(one_cycle), 32'd1);
        chk({tag, "_err"}, 32'(er), 32'(e_err));
        if (chk_rd) chk({tag, "_rdata"}, rd, e_rd);
        if (gnt_delay == 0) chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_reads"}, 32'(n_rd - r0), 32'(e_rds));
        chk({tag, "_writes"}, 32'(n_wr - w0), 32'(e_wrs));
        if (e_rds == 0 && e_wrs == 0) chk({tag, "_req_cycles"}, 32'(n_req_cyc - q0), 32'd0);
        if (e_wrs != 0) begin
            chk({tag, "_wdata"}, g_wdata, e_wr);
            chk({tag, "_waddr"}, g_addr, {addr[31:2], 2'b00});
        end
    endtask

    task automatic preset(input logic [31:0] addr, input logic [31:0] v);
        bus_mem[addr[11:2]] = v;
        ref_mem[addr[11:2]] = v;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] v, a;
        logic [5:0]  atop;
        logic [4:0]  rops [11] = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                                   F_MIN, F_MAX, F_MINU, F_MAXU};
        bit          found;
        int          r;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_atop = '0;
        res_clear_drv = 1'b0;
        for (int i = 0; i < 1024; i++) begin v = $urandom; preset(32'(i) << 2, v); end

        @(negedge clk);
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // AMOADD overflow boundary
        preset(32'h100, 32'h7FFF_FFFF);
        run_op("amoadd", {1'b1, F_ADD}, 32'h100, 32'd1);
        chk("amoadd_mem", bus_mem[32'h100 >> 2], 32'h8000_0000);

        // LR / SC pair, then a second SC that must fail without bus traffic
        run_op("lr1", {1'b1, F_LR}, 32'h200, 32'h0);
        run_op("sc1", {1'b1, F_SC}, 32'h200, 32'hA5);
        run_op("sc2", {1'b1, F_SC}, 32'h200, 32'h5A);

        // Reservation killed by an explicit clear pulse
        run_op("lr2", {1'b1, F_LR}, 32'h200, 32'h0);
        pulse_clear();
        run_op("sc3", {1'b1, F_SC}, 32'h200, 32'h11);

        // Clear coinciding with the LR read response
        clr_on_rd = 1;
        run_op("lr3", {1'b1, F_LR}, 32'h200, 32'h0);
        run_op("sc4", {1'b1, F_SC}, 32'h200, 32'h22);

        // Signed vs unsigned min on the same operands
        preset(32'h300, 32'hFFFF_FFFF);
        run_op("amomin", {1'b1, F_MIN}, 32'h300, 32'd1);
        preset(32'h300, 32'hFFFF_FFFF);
        run_op("amominu", {1'b1, F_MINU}, 32'h300, 32'd1);

        // Read error skips the write; misaligned never reaches the bus
        inject_rd_err = 1;
        run_op("swap_rderr", {1'b1, F_SWAP}, 32'h104, 32'h1234);
        run_op("misaligned", {1'b1, F_ADD}, 32'h102, 32'h1);

        // Delayed grants, then async reset while the write response is pending
        run_op("lr4", {1'b1, F_LR}, 32'h200, 32'h0);
        gnt_delay = 3;
        @(negedge clk);
        req_valid = 1'b1; req_atop = {1'b1, F_ADD}; req_addr = 32'h308; req_wdata = 32'h5;
        @(posedge clk); #1 req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (bus_gnt && bus_we) begin found = 1; break; end
        end
        chk("rst_wr_gnt_seen", 32'(found), 32'd1);
        chk("rst_wr_data", g_wdata, ref_mem[32'h308 >> 2] + 32'h5);
        drop_resp = 1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        m_res_vld = 0;
        gnt_delay = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", 32'(req_ready), 32'd1);
        run_op("sc_after_rst", {1'b1, F_SC}, 32'h200, 32'h33);

        // Randomized mix over a small address pool so reservations hit often
        for (int n = 0; n < 150; n++) begin
            gnt_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            if ($urandom_range(0, 5) == 0) pulse_clear();
            a = 32'h400 + (32'($urandom_range(0, 3)) << 2);
            r = $urandom_range(0, 15);
            if (r < 3)       atop = {1'b1, F_LR};
            else if (r < 6)  atop = {1'b1, F_SC};
            else if (r == 6) begin
                case ($urandom_range(0, 2))
                    0:       atop = {1'b0, rops[$urandom_range(0, 10)]};
                    1:       atop = {1'b1, 5'b00101};
                    default: begin atop = {1'b1, F_ADD}; a = a + 32'($urandom_range(1, 3)); end
                endcase
            end else         atop = {1'b1, rops[$urandom_range(0, 10)]};
            run_op("rand", atop, a, $urandom);
        end
        gnt_delay = 0;

        r = 0;
        for (int i = 0; i < 1024; i++) if (bus_mem[i] !== ref_mem[i]) r++;
        chk("mem_final_mismatches", 32'(r), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
